// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write bus of the loader.
//   s_data/s_valid/s_ready : byte stream, transfer when s_valid && s_ready at a rising edge
//   imem_we/imem_addr/imem_wdata : one-cycle word write strobe, word address, write data
// Modports: slave = loader side, master = stream source / memory side.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for MIPS_Core.
// Accepts a little-endian byte stream (header N, N data words, XOR checksum word), writes the
// data words into instruction memory and releases the core from reset only after the
// checksum matches.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   bus        : stream input + instruction-memory write port (imem_loader_if.slave)
//   restart    : reload request, honoured only in RUN or ERROR
//   core_rst   : active-high reset to the core
//   load_done  : program loaded and verified, core running
//   load_err   : load failed, core held in reset
// All outputs are registered.
module imem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    imem_loader_if.slave   bus,
    input  logic           restart,
    output logic           core_rst,
    output logic           load_done,
    output logic           load_err
);

    localparam int unsigned MaxWords = 2 ** ADDR_W;
    // One extra bit so a full-capacity program (N == MaxWords) is representable.
    localparam int unsigned IdxW = ADDR_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StLoad,
        StCsum,
        StRun,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       word_q, word_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [IdxW-1:0]   n_q, n_d;
    logic [31:0]       acc_q, acc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              s_ready_q, s_ready_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              fire;
    logic              last_byte;
    logic [31:0]       word;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        idx_d      = idx_q;
        n_d        = n_q;
        acc_d      = acc_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        fire      = bus.s_valid && s_ready_q;
        last_byte = (byte_cnt_q == 2'd3);
        // Complete word as it stands when the 4th byte is on the bus.
        word      = {bus.s_data, word_q};

        // s_ready is only high in HDR/LOAD/CSUM, so fire implies one of those states.
        if (fire) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            unique case (byte_cnt_q)
                2'd0:    word_d[7:0]   = bus.s_data;
                2'd1:    word_d[15:8]  = bus.s_data;
                2'd2:    word_d[23:16] = bus.s_data;
                default: ;
            endcase
        end

        unique case (state_q)
            StIdle: begin
                byte_cnt_d = 2'd0;
                word_d     = '0;
                idx_d      = '0;
                n_d        = '0;
                acc_d      = '0;
                state_d    = StHdr;
            end
            StHdr: begin
                if (fire && last_byte) begin
                    if (word > 32'(MaxWords)) begin
                        state_d = StError;
                    end else if (word == 32'd0) begin
                        state_d = StCsum;
                    end else begin
                        n_d     = word[IdxW-1:0];
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (fire && last_byte) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q[ADDR_W-1:0];
                    wdata_d = word;
                    acc_d   = acc_q ^ word;
                    idx_d   = idx_q + IdxW'(1);
                    if (idx_q + IdxW'(1) == n_q) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (fire && last_byte) begin
                    state_d = (word == acc_q) ? StRun : StError;
                end
            end
            StRun, StError: begin
                if (restart) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Status outputs are registered copies of the next state so they change on the
        // deciding edge itself.
        s_ready_d  = (state_d == StHdr) || (state_d == StLoad) || (state_d == StCsum);
        core_rst_d = (state_d != StRun);
        done_d     = (state_d == StRun);
        err_d      = (state_d == StError);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            byte_cnt_q <= 2'd0;
            word_q     <= '0;
            idx_q      <= '0;
            n_q        <= '0;
            acc_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            s_ready_q  <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            acc_q      <= acc_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            s_ready_q  <= s_ready_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign core_rst       = core_rst_q;
    assign load_done      = done_q;
    assign load_err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed streams, expected memory writes queued by the
// stimulus and popped by an independent write monitor.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;

    logic clk = 1'b0;
    logic rst;
    logic restart;
    logic core_rst, load_done, load_err;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] prog[3];

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .restart   (restart),
        .core_rst  (core_rst),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every imem_we cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write", {bus.imem_addr, bus.imem_wdata}, {e.addr, e.data});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bub);
        int n;
        int guard;
        if (bub) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(negedge clk);
                bus.s_valid = 1'b0;
                check("bubble_ready", bus.s_ready, 1);
            end
        end
        @(negedge clk);
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        guard = 0;
        while (bus.s_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            check("ready_timeout", 0, 1);
            bus.s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit bub);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], bub);
        end
    endtask

    task automatic check_status(input string name, input bit ok, input bit err);
        check({name, "_core_rst"}, core_rst, !ok);
        check({name, "_done"}, load_done, ok);
        check({name, "_err"}, load_err, err);
        check({name, "_s_ready"}, bus.s_ready, 0);
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    // Header n, words prog[0..n-1], then checksum; expected result ok (RUN) or ERROR.
    task automatic run_prog(input string name, input int n, input logic [31:0] csum,
                            input bit ok, input bit bub);
        send_word(32'(n), bub);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({i[ADDR_W-1:0], prog[i]});
            send_word(prog[i], bub);
            @(negedge clk);
            check({name, "_we_latency"}, bus.imem_we, 1);
        end
        check({name, "_core_rst_pre"}, core_rst, 1);
        send_word(csum, bub);
        @(negedge clk);
        check_status(name, ok, !ok);
    endtask

    task automatic do_restart(input string name);
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        @(negedge clk);
        check({name, "_core_rst"}, core_rst, 1);
        check({name, "_done"}, load_done, 0);
        check({name, "_err"}, load_err, 0);
        check({name, "_idle_ready"}, bus.s_ready, 0);
        @(negedge clk);
        check({name, "_hdr_ready"}, bus.s_ready, 1);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_s_ready"}, bus.s_ready, 0);
        check({name, "_we"}, bus.imem_we, 0);
        check({name, "_addr"}, bus.imem_addr, 0);
        check({name, "_wdata"}, bus.imem_wdata, 0);
        check({name, "_core_rst"}, core_rst, 1);
        check({name, "_done"}, load_done, 0);
        check({name, "_err"}, load_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        prog[0] = 32'h2008_0005;
        prog[1] = 32'h2129_0001;
        prog[2] = 32'h0800_0000;

        rst         = 1'b0;
        restart     = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);
        check("first_hdr_ready", bus.s_ready, 1);

        // Nominal load.
        run_prog("nominal", 3, 32'h0921_0004, 1'b1, 1'b0);

        // Bytes offered in RUN must not be accepted.
        @(negedge clk);
        bus.s_data  = 8'hAA;
        bus.s_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.s_valid = 1'b0;
        check("run_no_accept", bus.s_ready, 0);
        check("run_done_hold", load_done, 1);

        // Restart from RUN, then a load with a bad checksum.
        do_restart("restart_run");
        run_prog("bad_csum", 3, 32'h0000_0000, 1'b0, 1'b0);

        // Oversize header: ERROR at its 4th byte, no writes.
        do_restart("restart_err");
        send_word(32'd257, 1'b0);
        @(negedge clk);
        check_status("oversize", 1'b0, 1'b1);

        // Empty programs.
        do_restart("restart_e0");
        run_prog("empty_ok", 0, 32'h0000_0000, 1'b1, 1'b0);
        do_restart("restart_e1");
        run_prog("empty_bad", 0, 32'h0000_0001, 1'b0, 1'b0);

        // Nominal stream with random bubbles.
        do_restart("restart_bub");
        run_prog("bubbles", 3, 32'h0921_0004, 1'b1, 1'b1);

        // Asynchronous reset after 6 bytes, then a fresh load.
        do_restart("restart_rst");
        send_word(32'd3, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_hdr_ready", bus.s_ready, 1);
        run_prog("after_reset", 3, 32'h0921_0004, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("final_pending", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
